alu_exec: RTL and testbench

- Execution ALU that consumes the 5-bit ALUOperation codes produced by the ALU control unit.
- Single-cycle ops: add, sub, and, or, xor, signed slt, mflo, mfhi.
- Iterative 32-step signed multiply/divide that writes internal HI/LO registers.
- Sits in the EX stage; the datapath stalls on busy.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_exec_muldiv_seq.sv | 142 ++++++++++++++
 rtl/alu_exec.sv | 92 +++++++++
 tb/tb_alu_exec.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes issued by the ALU control unit and
// the multiply/divide sequencer state encoding.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLT  = 5'd5;
  localparam logic [4:0] OP_MFLO = 5'd11;
  localparam logic [4:0] OP_MFHI = 5'd12;
  localparam logic [4:0] OP_DIV  = 5'd13;
  localparam logic [4:0] OP_MULT = 5'd14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_exec_muldiv_seq.sv
// Iterative signed multiply / restoring divide on operand magnitudes, with a
// final sign-fix cycle that writes the HI/LO registers.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             fix,
  output logic [WIDTH-1:0] lo_next,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d, neg_q, neg_d, a_neg_q, a_neg_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] amag_q, amag_d, bmag_q, bmag_d;
  logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] a_abs, b_abs, fix_hi, fix_lo;
  logic [WIDTH:0]   sum, shifted;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic             ge;

  always_comb begin
    a_abs   = a[WIDTH-1] ? -a : a;
    b_abs   = b[WIDTH-1] ? -b : b;
    // Multiply: acc holds the running high half, sh the multiplier / low half.
    sum     = {1'b0, acc_q} + {1'b0, (sh_q[0] ? amag_q : '0)};
    // Divide: acc is the partial remainder, sh the dividend / quotient.
    shifted = {acc_q, sh_q[WIDTH-1]};
    ge      = shifted >= {1'b0, bmag_q};
    prod    = {acc_q, sh_q};
    prod_s  = neg_q ? -prod : prod;

    if (is_div_q) begin
      if (bmag_q == '0) begin
        fix_lo = '1;
        fix_hi = a_neg_q ? -amag_q : amag_q;
      end else begin
        fix_lo = neg_q ? -sh_q : sh_q;
        fix_hi = a_neg_q ? -acc_q : acc_q;
      end
    end else begin
      fix_hi = prod_s[2*WIDTH-1:WIDTH];
      fix_lo = prod_s[WIDTH-1:0];
    end

    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    a_neg_d  = a_neg_q;
    busy_d   = busy_q;
    amag_d   = amag_q;
    bmag_d   = bmag_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_CALC;
          cnt_d    = '0;
          is_div_d = is_div;
          neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
          a_neg_d  = a[WIDTH-1];
          busy_d   = 1'b1;
          amag_d   = a_abs;
          bmag_d   = b_abs;
          acc_d    = '0;
          sh_d     = is_div ? a_abs : b_abs;
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          acc_d = ge ? (shifted[WIDTH-1:0] - bmag_q) : shifted[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], ge};
        end else begin
          acc_d = sum[WIDTH:1];
          sh_d  = {sum[0], sh_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      busy_q   <= 1'b0;
      amag_q   <= '0;
      bmag_q   <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      a_neg_q  <= a_neg_d;
      busy_q   <= busy_d;
      amag_q   <= amag_d;
      bmag_q   <= bmag_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy    = busy_q;
  assign fix     = (state_q == S_FIX);
  assign lo_next = fix_lo;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: rtl/alu_exec.sv
// EX-stage ALU: single-cycle logic/arithmetic ops plus a start/busy/done
// handshake around the iterative multiply/divide sequencer.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       ALUOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             accept, is_md, md_start, md_busy, md_fix;
  logic [WIDTH-1:0] md_lo_next, md_hi, md_lo;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, done_q, done_d;

  assign accept   = start & ~md_busy;
  assign is_md    = (ALUOperation == OP_DIV) || (ALUOperation == OP_MULT);
  assign md_start = accept & is_md;

  muldiv_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (md_start),
    .is_div  (ALUOperation == OP_DIV),
    .a       (A),
    .b       (B),
    .busy    (md_busy),
    .fix     (md_fix),
    .lo_next (md_lo_next),
    .hi      (md_hi),
    .lo      (md_lo)
  );

  always_comb begin
    result_d = result_q;
    done_d   = 1'b0;
    // No new op can be accepted during FIX since busy is still high then.
    if (md_fix) begin
      result_d = md_lo_next;
      done_d   = 1'b1;
    end else if (accept && !is_md) begin
      done_d = 1'b1;
      case (ALUOperation)
        OP_ADD:  result_d = A + B;
        OP_SUB:  result_d = A - B;
        OP_AND:  result_d = A & B;
        OP_OR:   result_d = A | B;
        OP_XOR:  result_d = A ^ B;
        OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
        OP_MFLO: result_d = md_lo;
        OP_MFHI: result_d = md_hi;
        default: result_d = '0;
      endcase
    end
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign done   = done_q;
  assign busy   = md_busy;
  assign hi     = md_hi;
  assign lo     = md_lo;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: expectations are computed from a behavioural
// model when an op is presented and checked when done is observed.
module tb_alu_exec;

  localparam logic [4:0] C_ADD = 5'd0,  C_SUB = 5'd1,  C_AND = 5'd2,  C_OR = 5'd3;
  localparam logic [4:0] C_XOR = 5'd4,  C_SLT = 5'd5,  C_MFLO = 5'd11, C_MFHI = 5'd12;
  localparam logic [4:0] C_DIV = 5'd13, C_MULT = 5'd14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  ALUOperation = '0;
  logic [31:0] A = '0, B = '0;
  logic [31:0] result, hi, lo;
  logic        zero, busy, done;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        scb[$];
  logic [31:0] m_hi = '0, m_lo = '0;
  int          checks = 0;
  int          errors = 0;

  alu_exec #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ALUOperation (ALUOperation),
    .A            (A),
    .B            (B),
    .result       (result),
    .zero         (zero),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;

  task automatic push_expect(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] pa, pb, p;
    logic signed [31:0] da, db;
    case (op)
      C_ADD:  e.res = a + b;
      C_SUB:  e.res = a - b;
      C_AND:  e.res = a & b;
      C_OR:   e.res = a | b;
      C_XOR:  e.res = a ^ b;
      C_SLT:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      C_MFLO: e.res = m_lo;
      C_MFHI: e.res = m_hi;
      C_MULT: begin
        pa = {{32{a[31]}}, a};
        pb = {{32{b[31]}}, b};
        p  = pa * pb;
        m_hi = p[63:32];
        m_lo = p[31:0];
        e.res = m_lo;
      end
      C_DIV: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 32'd0;
        end else begin
          da = a;
          db = b;
          m_lo = da / db;
          m_hi = da % db;
        end
        e.res = m_lo;
      end
      default: e.res = 32'd0;
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
    scb.push_back(e);
  endtask

  // Presents one op across one rising edge; returns #1 after that edge.
  task automatic drive_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit expect_it);
    @(negedge clk);
    start = 1'b1;
    ALUOperation = op;
    A = a;
    B = b;
    if (expect_it) push_expect(op, a, b);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < max) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({result, zero, busy, done, hi, lo} !== {32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset: result=%h zero=%b busy=%b done=%b hi=%h lo=%h, expected 0/1/0/0/0/0",
               result, zero, busy, done, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    logic [4:0]  ops[8]  = '{C_SUB, C_SLT, C_SLT, C_ADD, C_AND, C_OR, C_XOR, C_SLT};
    logic [31:0] as[8]   = '{32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_1234,
                             32'h0F00_0001, 32'hAAAA_5555, 32'd7};
    logic [31:0] bs[8]   = '{32'd7, 32'd7, 32'd1, 32'd1, 32'h0FF0_FF00, 32'h00F0_0010,
                             32'hFFFF_0000, 32'hFFFF_FFF0};
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      drive_op(ops[i], as[i], bs[i], 1'b1);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL single_done[%0d]: done=%b busy=%b, expected done=1 busy=0", i, done, busy);
      end
      e = scb.pop_front();
      checks++;
      if ({result, zero, hi, lo} !== {e.res, (e.res == 32'd0), e.hi, e.lo}) begin
        errors++;
        $display("FAIL single[%0d]: result=%h zero=%b hi=%h lo=%h, expected result=%h zero=%b hi=%h lo=%h",
                 i, result, zero, hi, lo, e.res, (e.res == 32'd0), e.hi, e.lo);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL single_pulse[%0d]: done=%b, expected 0", i, done);
      end
    end
  endtask

  task automatic test_muldiv;
    logic [4:0]  ops[6] = '{C_MULT, C_DIV, C_DIV, C_DIV, C_DIV, C_MULT};
    logic [31:0] as[6]  = '{32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFF9, 32'd9, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs[6]  = '{32'd7, 32'hFFFF_FFFE, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000};
    exp_t e;
    int cyc;
    for (int i = 0; i < 6; i++) begin
      drive_op(ops[i], as[i], bs[i], 1'b1);
      A = $urandom;
      B = $urandom;
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL md_busy[%0d]: busy=%b, expected 1", i, busy);
      end
      wait_done(40, cyc);
      checks++;
      if (done !== 1'b1 || cyc != 33) begin
        errors++;
        $display("FAIL md_latency[%0d]: done=%b after %0d cycles, expected done=1 after 33", i, done, cyc);
      end
      if (done === 1'b1) begin
        e = scb.pop_front();
        checks++;
        if ({result, zero, hi, lo, busy} !== {e.res, (e.res == 32'd0), e.hi, e.lo, 1'b0}) begin
          errors++;
          $display("FAIL md[%0d]: result=%h hi=%h lo=%h busy=%b, expected result=%h hi=%h lo=%h busy=0",
                   i, result, hi, lo, busy, e.res, e.hi, e.lo);
        end
      end else begin
        void'(scb.pop_front());
      end
      // Read back HI in the same cycle the done pulse is visible.
      drive_op(C_MFHI, 32'd0, 32'd0, 1'b1);
      e = scb.pop_front();
      checks++;
      if (done !== 1'b1 || result !== e.res) begin
        errors++;
        $display("FAIL mfhi[%0d]: done=%b result=%h, expected done=1 result=%h", i, done, result, e.res);
      end
    end
    drive_op(C_MFLO, 32'd0, 32'd0, 1'b1);
    e = scb.pop_front();
    checks++;
    if (result !== e.res) begin
      errors++;
      $display("FAIL mflo: result=%h, expected %h", result, e.res);
    end
  endtask

  task automatic test_illegal;
    exp_t e;
    logic [4:0] codes[3] = '{5'd7, 5'd15, 5'd31};
    for (int i = 0; i < 3; i++) begin
      drive_op(codes[i], 32'h1234_5678, 32'h0000_0001, 1'b1);
      e = scb.pop_front();
      checks++;
      if ({done, result, zero, hi, lo} !== {1'b1, 32'd0, 1'b1, e.hi, e.lo}) begin
        errors++;
        $display("FAIL illegal[%0d]: done=%b result=%h zero=%b hi=%h lo=%h, expected 1/0/1/%h/%h",
                 i, done, result, zero, hi, lo, e.hi, e.lo);
      end
    end
  endtask

  task automatic test_busy_ignore;
    exp_t e;
    logic [31:0] prev;
    int ndone = 0;
    int bad_hold = 0;
    drive_op(C_ADD, 32'd40, 32'd2, 1'b1);
    void'(scb.pop_front());
    prev = result;
    drive_op(C_MULT, 32'd1000, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = (i < 5);
      ALUOperation = C_ADD;
      A = 32'd1;
      B = 32'd2;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (scb.size() != 0) begin
          e = scb.pop_front();
          checks++;
          if ({result, hi, lo} !== {e.res, e.hi, e.lo}) begin
            errors++;
            $display("FAIL busy_mult: result=%h hi=%h lo=%h, expected %h/%h/%h",
                     result, hi, lo, e.res, e.hi, e.lo);
          end
        end
      end else if (ndone == 0 && result !== prev) begin
        bad_hold++;
      end
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL busy_done_count: saw %0d done pulses, expected 1", ndone);
    end
    checks++;
    if (bad_hold != 0) begin
      errors++;
      $display("FAIL busy_hold: result changed %0d times while busy, expected 0", bad_hold);
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] pool[9] = '{C_ADD, C_SUB, C_AND, C_OR, C_XOR, C_SLT, C_MFLO, C_MFHI, 5'd9};
    exp_t e;
    int bad = 0;
    for (int i = 0; i < 12; i++) begin
      drive_op(pool[$urandom_range(0, 8)], $urandom, $urandom, 1'b1);
      e = scb.pop_front();
      checks++;
      if (done !== 1'b1 || {result, zero} !== {e.res, (e.res == 32'd0)}) begin
        errors++;
        bad++;
        $display("FAIL b2b[%0d]: done=%b result=%h zero=%b, expected done=1 result=%h zero=%b",
                 i, done, result, zero, e.res, (e.res == 32'd0));
      end
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int cyc;
    drive_op(C_MULT, 32'h0001_0001, 32'h0002_0003, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    m_hi = '0;
    m_lo = '0;
    #1;
    checks++;
    if ({hi, lo, busy, done, result} !== {32'd0, 32'd0, 1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b result=%h, expected all 0",
               hi, lo, busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(40, cyc);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: done=%b after %0d cycles, expected no pulse", done, cyc);
    end
    drive_op(C_ADD, 32'd100, 32'd23, 1'b1);
    e = scb.pop_front();
    checks++;
    if ({done, result, hi, lo} !== {1'b1, e.res, e.hi, e.lo}) begin
      errors++;
      $display("FAIL reset_add: done=%b result=%h hi=%h lo=%h, expected 1/%h/%h/%h",
               done, result, hi, lo, e.res, e.hi, e.lo);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_muldiv;
    test_illegal;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    checks++;
    if (scb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", scb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
